// File: rtl/img_capture.sv
// img_capture: head of the image pipeline. Assembles one raster frame from
// the camera pixel stream into a flat matrix, then offers it downstream via
// a four-phase Req/Ack handshake. Single buffer: the stream is stalled
// (PixReady=0) for the whole hand-off.
module img_capture #(
    parameter int IMAGE_BITS = 8,
    parameter int MATRIX_N   = 120,
    parameter int MATRIX_M   = 120,
    parameter int FLAT_WIDE  = IMAGE_BITS*MATRIX_N*MATRIX_M,
    parameter int CNT_BITS   = $clog2(MATRIX_N*MATRIX_M)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [IMAGE_BITS-1:0] PixIn,
    input  logic                  PixValid,
    input  logic                  PixSof,
    output logic                  PixReady,
    output logic                  ReqOut,
    input  logic                  AckOut,
    output logic [FLAT_WIDE-1:0]  ImgMatOut,
    output logic                  SofErr
);

    localparam int NPIX = MATRIX_N*MATRIX_M;
    // A 1x1 matrix gives a zero-width index; keep at least one bit.
    localparam int CW   = (CNT_BITS < 1) ? 1 : CNT_BITS;

    typedef enum logic [1:0] {HUNT, FILL, REQ, ACKLOW} state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [FLAT_WIDE-1:0] r_img;
    logic                 r_ready;
    logic                 r_req;
    logic                 r_sof_err;

    logic                 w_xfer;
    logic                 w_last;

    assign w_xfer    = PixValid & r_ready;
    assign w_last    = (r_cnt == CW'(NPIX-1));

    assign PixReady  = r_ready;
    assign ReqOut    = r_req;
    assign ImgMatOut = r_img;
    assign SofErr    = r_sof_err;

    // Capture FSM: all outputs registered, frame buffer written only on transfers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= HUNT;
            r_cnt     <= '0;
            r_img     <= '0;
            r_ready   <= 1'b0;
            r_req     <= 1'b0;
            r_sof_err <= 1'b0;
        end else begin
            r_sof_err <= 1'b0;
            unique case (r_state)
                HUNT: begin
                    r_ready <= 1'b1;
                    // Anything before a SOF is dropped on the floor.
                    if (w_xfer && PixSof) begin
                        r_img[0 +: IMAGE_BITS] <= PixIn;
                        if (NPIX == 1) begin
                            r_cnt   <= '0;
                            r_state <= REQ;
                            r_ready <= 1'b0;
                            r_req   <= 1'b1;
                        end else begin
                            r_cnt   <= CW'(1);
                            r_state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (w_xfer) begin
                        if (PixSof) begin
                            // Restart mid-frame; stale upper pixels get overwritten.
                            r_img[0 +: IMAGE_BITS] <= PixIn;
                            r_cnt     <= CW'(1);
                            r_sof_err <= 1'b1;
                        end else begin
                            r_img[int'(r_cnt)*IMAGE_BITS +: IMAGE_BITS] <= PixIn;
                            if (w_last) begin
                                r_cnt   <= '0;
                                r_state <= REQ;
                                r_ready <= 1'b0;
                                r_req   <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                end
                REQ: begin
                    if (AckOut) begin
                        r_req   <= 1'b0;
                        r_state <= ACKLOW;
                    end
                end
                ACKLOW: begin
                    if (!AckOut) begin
                        r_state <= HUNT;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

endmodule

// File: doc/img_capture.md
Name: img_capture

Overview:
- Frame source at the head of the image pipeline: accepts a raster pixel stream from the camera interface and assembles one full flat image matrix.
- Presents the matrix to the pre-processing stage through the Req/Ack four-phase handshake. It is the initiator whose ReqOut/AckOut pair feeds a stage's ReqIn/AckIn.
- Single frame buffer. The pixel stream is back-pressured while a frame is being handed off.

Parameters:
- IMAGE_BITS, 8, bits per pixel.
- MATRIX_N, 120, pixels across (columns).
- MATRIX_M, 120, pixels down (rows).
- FLAT_WIDE, IMAGE_BITS*MATRIX_N*MATRIX_M, flat matrix width.
- CNT_BITS, clog2(MATRIX_N*MATRIX_M), pixel index counter width.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous reset, active-low (0 = reset).
- PixIn  in  IMAGE_BITS  pixel data from camera.
- PixValid  in  1  PixIn valid this cycle.
- PixSof  in  1  start-of-frame marker, qualified by PixValid.
- PixReady  out  1  capture can accept a pixel; transfer = PixValid & PixReady.
- ReqOut  out  1  request to next stage; ImgMatOut valid and stable while high.
- AckOut  in  1  acknowledge from next stage.
- ImgMatOut  out  FLAT_WIDE  assembled frame; pixel k at bits [k*IMAGE_BITS +: IMAGE_BITS], k = row*MATRIX_N + col.
- SofErr  out  1  one-cycle pulse: SOF seen mid-frame, partial frame discarded.

Behaviour:
- Reset (Reset=0 at a rising edge): state HUNT, counter 0, ImgMatOut all 0, ReqOut 0, PixReady 0, SofErr 0. Reset applied mid-handshake drops ReqOut on that edge. The partial frame is discarded.
- States: HUNT, FILL, REQ, ACKLOW.
- PixReady is registered and equals 1 in HUNT and FILL, 0 in REQ and ACKLOW.
- HUNT:
  - A transfer with PixSof=0 is discarded.
  - A transfer with PixSof=1 writes pixel 0 and sets counter to 1. Next state is FILL.
  - If MATRIX_N*MATRIX_M = 1, next state is REQ.
- FILL:
  - Each transfer with PixSof=0 writes pixel[counter] and increments the counter.
  - The transfer writing index N*M-1 moves the state to REQ; the counter wraps to 0.
  - A transfer with PixSof=1 in FILL (counter != 0) pulses SofErr on the next cycle. That pixel is written to index 0, counter becomes 1, and the state stays FILL. Stale upper pixels are overwritten as the new frame fills.
- REQ:
  - ReqOut=1 from the cycle after the last pixel transfer (latency 1).
  - ImgMatOut is held stable.
  - On a sampled AckOut=1, ReqOut goes to 0 on the next edge and the state moves to ACKLOW.
- ACKLOW:
  - Waits for sampled AckOut=0, then moves to HUNT.
  - PixReady=1 on the cycle after.
  - The new frame requires a SOF.
- AckOut=1 sampled while not in REQ is ignored.
- AckOut already high when REQ is entered is accepted immediately: ReqOut is high for exactly 1 cycle.
- ImgMatOut changes only on pixel writes, so it is stable across REQ and ACKLOW.
- PixValid with PixReady=0 causes no write and no state change; the source holds the pixel.
- No combinational paths from inputs to outputs.

Test Plan (MATRIX_N=4, MATRIX_M=4, IMAGE_BITS=8):
1. Reset held low 3 cycles while PixValid=1 -> PixReady=0, ReqOut=0, ImgMatOut=0. Release -> PixReady=1 next cycle.
2. Stream 0x00..0x0F back-to-back, SOF on 0x00 -> ReqOut rises the cycle after 0x0F is accepted, and PixReady falls. ImgMatOut[7:0]=0x00, [127:120]=0x0F.
3. Ack timing: AckOut raised 5 cycles after ReqOut -> ReqOut low one cycle later. AckOut lowered 2 cycles later -> PixReady=1 the following cycle. Second frame 0x10..0x1F is captured correctly.
4. Three pixels without SOF, then a SOF frame -> the first three are discarded. The frame matches pixel values starting at the SOF pixel.
5. SOF frame interrupted by SOF after 7 pixels -> one SofErr pulse. The final ImgMatOut holds only the second frame's 16 pixels.
6. Reset asserted while ReqOut=1 with AckOut=0 -> ReqOut=0 next edge, state HUNT. A subsequent full frame handshakes normally.
